// File: rtl/logic_unit_mt.sv
// logic_unit_mt: per-thread logic result buffer.
// One pipeline register captures the issue; the next edge computes the bitwise
// result and writes {C,V,N,Z,result} into a small result RAM. Two independent
// read ports with write-first bypass and a per-entry valid bitmap.
module logic_unit_mt #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDRS_WIDTH = 4
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    wren,
   input  logic [ADDRS_WIDTH-1:0]  wraddrs,
   input  logic [2:0]              opsel,
   input  logic [DATA_WIDTH-1:0]   oprndA,
   input  logic [DATA_WIDTH-1:0]   oprndB,
   input  logic                    C,
   input  logic                    V,
   input  logic                    rdenA,
   input  logic                    rdenB,
   input  logic [ADDRS_WIDTH-1:0]  rdaddrsA,
   input  logic [ADDRS_WIDTH-1:0]  rdaddrsB,
   output logic [DATA_WIDTH+3:0]   rddataA,
   output logic [DATA_WIDTH+3:0]   rddataB,
   output logic                    ready
);

   localparam int DEPTH = 2 ** ADDRS_WIDTH;
   localparam int WW    = DATA_WIDTH + 4;

   // Bitwise operation selected by the 3-bit opcode.
   function automatic logic [DATA_WIDTH-1:0] logic_op(
      input logic [2:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH-1:0] r;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~(a & b);
         3'b100:  r = ~(a | b);
         3'b101:  r = ~(a ^ b);
         3'b110:  r = a & ~b;
         3'b111:  r = a;
         default: r = a;
      endcase
      return r;
   endfunction

   // Stage-1 issue registers
   logic                    s1_vld_q;
   logic [2:0]              s1_op_q;
   logic [DATA_WIDTH-1:0]   s1_a_q;
   logic [DATA_WIDTH-1:0]   s1_b_q;
   logic                    s1_c_q;
   logic                    s1_v_q;
   logic [ADDRS_WIDTH-1:0]  s1_addr_q;

   // Result storage
   logic [WW-1:0]           ram_q [DEPTH];
   logic [DEPTH-1:0]        valid_q;

   // Write word and read-port next state
   logic [DATA_WIDTH-1:0]   res_s;
   logic [WW-1:0]           wr_word_s;
   logic [WW-1:0]           rd_a_d, rd_a_q;
   logic [WW-1:0]           rd_b_d, rd_b_q;
   logic                    ready_q;

   // Capture operands on issue; an idle cycle retires the stage-1 slot.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         s1_vld_q  <= 1'b0;
         s1_op_q   <= 3'b000;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_c_q    <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_addr_q <= '0;
      end else if (wren) begin
         s1_vld_q  <= 1'b1;
         s1_op_q   <= opsel;
         s1_a_q    <= oprndA;
         s1_b_q    <= oprndB;
         s1_c_q    <= C;
         s1_v_q    <= V;
         s1_addr_q <= wraddrs;
      end else begin
         s1_vld_q  <= 1'b0;
      end
   end

   // Stage-2 result word: flags captured at issue plus N/Z derived from the result.
   always_comb begin
      res_s     = logic_op(s1_op_q, s1_a_q, s1_b_q);
      wr_word_s = {s1_c_q, s1_v_q, res_s[DATA_WIDTH-1], ~|res_s, res_s};
   end

   // Result RAM write; contents are masked by the valid bitmap so no reset is needed.
   always_ff @(posedge CLK) begin
      if (s1_vld_q) begin
         ram_q[s1_addr_q] <= wr_word_s;
      end
   end

   // Valid bitmap: set on write, cleared only by reset (which also drops an in-flight issue).
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         valid_q <= '0;
      end else if (s1_vld_q) begin
         valid_q[s1_addr_q] <= 1'b1;
      end
   end

   // Read-port next state: bypass the word being written, else RAM if valid, else zero; hold when idle.
   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (rdenA) begin
         if (s1_vld_q && (rdaddrsA == s1_addr_q)) begin
            rd_a_d = wr_word_s;
         end else if (valid_q[rdaddrsA]) begin
            rd_a_d = ram_q[rdaddrsA];
         end else begin
            rd_a_d = '0;
         end
      end else begin
         rd_a_d = rd_a_q;
      end
      if (rdenB) begin
         if (s1_vld_q && (rdaddrsB == s1_addr_q)) begin
            rd_b_d = wr_word_s;
         end else if (valid_q[rdaddrsB]) begin
            rd_b_d = ram_q[rdaddrsB];
         end else begin
            rd_b_d = '0;
         end
      end else begin
         rd_b_d = rd_b_q;
      end
   end

   // Registered read data and the issue/read collision indicator.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rd_a_q  <= '0;
         rd_b_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
         ready_q <= !(wren && (rdenA || rdenB));
      end
   end

   assign rddataA = rd_a_q;
   assign rddataB = rd_b_q;
   assign ready   = ready_q;

endmodule

// File: tb/tb_logic_unit_mt.sv
// Directed bench for logic_unit_mt: expected read words are queued when a read
// is driven and popped when the registered read data appears.
module tb_logic_unit_mt;

   localparam int DW = 64;
   localparam int AW = 4;
   localparam int WW = DW + 4;

   logic          CLK;
   logic          RESET;
   logic          wren;
   logic [AW-1:0] wraddrs;
   logic [2:0]    opsel;
   logic [DW-1:0] oprndA, oprndB;
   logic          C, V;
   logic          rdenA, rdenB;
   logic [AW-1:0] rdaddrsA, rdaddrsB;
   logic [WW-1:0] rddataA, rddataB;
   logic          ready;

   int checks   = 0;
   int failures = 0;

   logic [WW-1:0] qa[$];
   logic [WW-1:0] qb[$];
   logic [WW-1:0] last_a, last_b;
   logic [WW-1:0] exp_mem [16];
   logic [DW-1:0] sweep_tbl [8];

   logic_unit_mt #(.DATA_WIDTH(DW), .ADDRS_WIDTH(AW)) dut (
      .CLK(CLK), .RESET(RESET), .wren(wren), .wraddrs(wraddrs), .opsel(opsel),
      .oprndA(oprndA), .oprndB(oprndB), .C(C), .V(V),
      .rdenA(rdenA), .rdenB(rdenB), .rdaddrsA(rdaddrsA), .rdaddrsB(rdaddrsB),
      .rddataA(rddataA), .rddataB(rddataB), .ready(ready)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [WW-1:0] mk(input logic c, input logic v, input logic [DW-1:0] r);
      return {c, v, r[DW-1], (r == 64'h0), r};
   endfunction

   task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [AW-1:0] addr, input logic [2:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic c, input logic v);
      wren = 1'b1; wraddrs = addr; opsel = op; oprndA = a; oprndB = b; C = c; V = v;
   endtask

   task automatic read_a(input logic [AW-1:0] addr, input logic [WW-1:0] exp);
      rdenA = 1'b1; rdaddrsA = addr; qa.push_back(exp);
   endtask

   task automatic read_b(input logic [AW-1:0] addr, input logic [WW-1:0] exp);
      rdenB = 1'b1; rdaddrsB = addr; qb.push_back(exp);
   endtask

   // One clock: sample just after the edge, compare read ports (new word or held word) and ready.
   task automatic tick(input string tag);
      logic exp_rdy;
      exp_rdy = !(wren && (rdenA || rdenB));
      @(posedge CLK);
      #1;
      if (rdenA) begin
         if (qa.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_qa observed=empty expected=entry", tag);
         end else begin
            last_a = qa.pop_front();
         end
      end
      if (rdenB) begin
         if (qb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_qb observed=empty expected=entry", tag);
         end else begin
            last_b = qb.pop_front();
         end
      end
      check({tag, "_rdA"}, rddataA, last_a);
      check({tag, "_rdB"}, rddataB, last_b);
      check({tag, "_ready"}, {{(WW-1){1'b0}}, ready}, {{(WW-1){1'b0}}, exp_rdy});
      wren = 1'b0; rdenA = 1'b0; rdenB = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] bp_val;
      sweep_tbl[0] = 64'h1111_1111_1111_1111;
      sweep_tbl[1] = 64'h7777_7777_7777_7777;
      sweep_tbl[2] = 64'h6666_6666_6666_6666;
      sweep_tbl[3] = 64'hEEEE_EEEE_EEEE_EEEE;
      sweep_tbl[4] = 64'h8888_8888_8888_8888;
      sweep_tbl[5] = 64'h9999_9999_9999_9999;
      sweep_tbl[6] = 64'h4444_4444_4444_4444;
      sweep_tbl[7] = 64'h5555_5555_5555_5555;
      last_a = '0; last_b = '0;
      RESET = 1'b0; wren = 1'b0; wraddrs = '0; opsel = 3'b000;
      oprndA = '0; oprndB = '0; C = 1'b0; V = 1'b0;
      rdenA = 1'b0; rdenB = 1'b0; rdaddrsA = '0; rdaddrsB = '0;

      // Reset state
      #1 RESET = 1'b1;
      #1;
      check("rst_rdA", rddataA, '0);
      check("rst_rdB", rddataB, '0);
      check("rst_ready", {{(WW-1){1'b0}}, ready}, {{(WW-1){1'b0}}, 1'b1});
      @(negedge CLK);
      RESET = 1'b0;

      // Read of an unwritten entry returns zero
      read_a(4'd3, '0);
      tick("rd_invalid");

      // AND with flags, read two cycles after issue
      issue(4'd5, 3'b000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 1'b0);
      tick("and_issue");
      tick("and_wait");
      read_a(4'd5, {4'b1010, 64'hF000_F000_F000_F000});
      tick("and_read");

      // Sweep all opcodes, one issue per cycle, to addresses 0..7
      for (int i = 0; i < 8; i++) begin
         issue(i[AW-1:0], i[2:0], 64'h5555_5555_5555_5555, 64'h3333_3333_3333_3333, i[0], i[1]);
         exp_mem[i] = mk(i[0], i[1], sweep_tbl[i]);
         tick("sweep_issue");
      end
      tick("sweep_drain");
      for (int i = 0; i < 8; i++) begin
         read_a(i[AW-1:0], exp_mem[i]);
         read_b(4'(7 - i), exp_mem[7 - i]);
         tick("sweep_read");
      end

      // XOR of equal operands sets Z
      issue(4'd12, 3'b010, 64'hDEAD_BEEF_0BAD_F00D, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
      tick("xorz_issue");
      tick("xorz_wait");
      read_a(4'd12, {4'b0001, 64'h0});
      tick("xorz_read");

      // Bypass: same-edge read sees old contents, next edge sees new word on both ports
      bp_val = 64'h8F0F_0000_1234_5679;
      issue(4'd9, 3'b001, 64'h0F0F_0000_1234_5678, 64'h8000_0000_0000_0001, 1'b0, 1'b1);
      read_a(4'd9, '0);
      read_b(4'd9, '0);
      tick("byp_same_edge");
      read_a(4'd9, {4'b0110, bp_val});
      read_b(4'd9, {4'b0110, bp_val});
      tick("byp_next_edge");
      read_a(4'd9, {4'b0110, bp_val});
      tick("byp_ram");

      // Collision on port B only, then issue without reads
      issue(4'd14, 3'b111, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b0);
      read_b(4'd9, {4'b0110, bp_val});
      tick("coll_b");
      tick("coll_recover");
      issue(4'd15, 3'b111, 64'h0, 64'h0, 1'b0, 1'b0);
      tick("wren_alone");

      // Back-to-back issues to addr 2: later one wins
      issue(4'd2, 3'b000, 64'hFFFF_0000_FFFF_0000, 64'h00FF_00FF_00FF_00FF, 1'b0, 1'b0);
      tick("b2b_and");
      issue(4'd2, 3'b001, 64'hFFFF_0000_FFFF_0000, 64'h00FF_00FF_00FF_00FF, 1'b1, 1'b1);
      tick("b2b_or");
      read_b(4'd2, {4'b1110, 64'hFFFF_00FF_FFFF_00FF});
      tick("b2b_bypass");
      read_a(4'd2, {4'b1110, 64'hFFFF_00FF_FFFF_00FF});
      tick("b2b_read");

      // Reset between issue and write: in-flight issue dropped, all entries invalid
      issue(4'd2, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
      tick("rst_mid_issue");
      #1 RESET = 1'b1;
      #1;
      check("rst_mid_rdA", rddataA, '0);
      check("rst_mid_rdB", rddataB, '0);
      check("rst_mid_ready", {{(WW-1){1'b0}}, ready}, {{(WW-1){1'b0}}, 1'b1});
      last_a = '0; last_b = '0;
      #1 RESET = 1'b0;
      tick("rst_mid_idle");
      read_a(4'd2, '0);
      read_b(4'd5, '0);
      tick("rst_mid_read");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/logic_unit_mt.md
# logic_unit_mt

Parametrised, multi-function successor to the thread-indexed logic result buffers. Applies a selectable bitwise operation (AND/OR/XOR/NAND/NOR/XNOR/ANDN/PASS) to two operands through one pipeline register, then stores result, N/Z flags and the C/V flags captured at issue into a per-thread result RAM. Two independent synchronous read ports serve the CPU operand fetch paths, with write-first bypass and per-entry valid tracking.

## Interface
- DATA_WIDTH, 64, operand/result width (≥8)
- ADDRS_WIDTH, 4, result-RAM address width incl. thread#; depth = 2**ADDRS_WIDTH
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- wren  in  1  issue: capture operands/op this cycle
- wraddrs  in  ADDRS_WIDTH  destination entry (incl. thread#)
- opsel  in  3  operation select
- oprndA, oprndB  in  DATA_WIDTH  operands
- C, V  in  1  carry/overflow flags captured at issue
- rdenA, rdenB  in  1  read enables
- rdaddrsA, rdaddrsB  in  ADDRS_WIDTH  read addresses (incl. thread#)
- rddataA, rddataB  out  DATA_WIDTH+4  {C, V, N, Z, result}
- ready  out  1  registered; low one cycle after an issue/read collision

## Operation
- opsel: 000 A&B, 001 A|B, 010 A^B, 011 ~(A&B), 100 ~(A|B), 101 ~(A^B), 110 A&~B, 111 A.
- Stage 1 (issue edge): if wren, register opsel, oprndA, oprndB, C, V, wraddrs; set s1_vld. If !wren, s1_vld cleared.
- Stage 2 (next edge): if s1_vld, compute R per opsel, N = R[DATA_WIDTH-1], Z = ~|R; write {C,V,N,Z,R} to RAM[s1_addr]; set valid[s1_addr].
- valid bitmap, one bit per entry; cleared only by RESET; never cleared by reads.
- Read port X (A or B, independent, identical): on edge with rdenX:
  - if s1_vld and rdaddrsX == s1_addr: rddataX <= word being written this edge (write-first bypass);
  - else if valid[rdaddrsX]: rddataX <= RAM[rdaddrsX];
  - else rddataX <= 0.
  - rdenX low: rddataX holds.
- Both ports may read the same address; both may hit the bypass simultaneously.
- Back-to-back issues to the same address: later issue wins; each written in order.
- ready <= !(wren && (rdenA || rdenB)).
- RAM contents themselves need no reset; valid bitmap masks them.

## Timing
- Reset values: rddataA = rddataB = 0, ready = 1, s1_vld = 0, valid = all 0. Async assert clears immediately; deassert synchronous to CLK by the surrounding design.
- Reset mid-operation: in-flight stage-1 issue is discarded (no RAM write, entry stays invalid).
- Issue latency: wren at edge k -> RAM/valid updated at edge k+1.
- Read latency: 1 cycle (rden at edge j -> rddata valid after edge j).
- Issue-to-read: read sampled at edge k (same edge as wren) returns old contents; read sampled at edge k+1 returns new result via bypass; from k+2 from RAM.
- ready: collision at edge k -> ready low after edge k, high after edge k+1 unless another collision.
- Throughput: one issue per cycle, two reads per cycle, no stalls.

## Test plan
- Reset then rdenA at addr 3 -> rddataA = 0, ready = 1; assert RESET mid-run -> all outputs 0/1 immediately.
- DATA_WIDTH=64: issue opsel=000, A=F0F0_..._F0F0, B=FF00_..._FF00, C=1, V=0 to addr 5; read addr 5 two cycles later -> {1,0,1,0,F000_..._F000}.
- Sweep all 8 opsel with A=0x5555..., B=0x3333... -> results 0x1111, 0x7777, 0x6666, 0xEEEE, 0x8888, 0x9999, 0x4444, 0x5555 patterns; XOR with A=B -> Z=1, result 0.
- Bypass: issue to addr 9 at edge k; rdenA and rdenB addr 9 at edge k -> old (0 if invalid); at edge k+1 -> new value on both ports.
- Collision: wren=1, rdenB=1 same cycle -> ready=0 for exactly one cycle; wren alone -> ready stays 1.
- Back-to-back issues to addr 2 (AND then OR) at edges k, k+1 -> read at k+3 returns OR result; reset between k and k+1 -> addr 2 reads 0.
